xs3_accum: RTL
==============

Name: xs3_accum

Overview:
- Sequential consumer stage for the binary-to-excess-3 digit converter.
- Accepts one two-digit excess-3 operand per valid/ready handshake: units digit plus tens digit.
- Adds the operand into an NDIG-digit excess-3 running sum, one digit per clock through a digit-serial adder FSM.
- Sits directly downstream of the converter and feeds display/readout logic.

Parameters:
- NDIG, 3, number of excess-3 digits in the accumulator; legal values are 2 or more.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear of the sum and flags; highest synchronous priority.
- in_valid  input  1  operand present on in_lo and in_hi.
- in_ready  output  1  block can accept an operand this cycle.
- in_lo  input  4  units digit of the operand, excess-3 coded.
- in_hi  input  4  tens digit of the operand, excess-3 coded.
- acc_xs3  output  4*NDIG  running sum, excess-3; digit 0 is in bits [3:0].
- done  output  1  one-cycle pulse when acc_xs3 has just been updated.
- busy  output  1  FSM is not in IDLE.
- ovf  output  1  sticky flag: the sum has wrapped past 10^NDIG-1.
- err  output  1  sticky flag: an illegal excess-3 code was offered.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - acc_xs3 and the working register = every digit 4'b0011 (decimal 0).
  - state=IDLE, done=0, ovf=0, err=0, busy=0, digit index=0.
  - in_ready goes high once rst_n is released.
  - Reset mid-ADD discards the operation; no done pulse.
- Legal excess-3 digit range: 4'b0011..4'b1100.
- in_ready = (state==IDLE) && !clr. A transfer occurs when in_valid && in_ready.
- FSM states: IDLE, CHECK, ADD, DONE.
- IDLE:
  - On a transfer, latch in_lo and in_hi, copy acc_xs3 into the working register, and go to CHECK.
  - in_valid while not ready is ignored; the source must hold its data.
- CHECK (1 cycle):
  - If either latched digit is illegal: set err, leave acc unchanged, no done, return to IDLE.
  - Otherwise go to ADD with index=0 and carry=0.
- ADD (NDIG cycles, index 0..NDIG-1):
  - Operand digit: index0=in_lo, index1=in_hi, higher indexes=4'b0011.
  - raw = a + b + carry, computed 5 bits wide.
  - If raw[4]=1: digit = raw[3:0] + 3, carry=1.
  - Else: digit = raw[3:0] - 3, carry=0.
  - The result is written into the working register at index; index increments.
  - After index NDIG-1, go to DONE.
- DONE (1 cycle):
  - acc_xs3 is loaded from the working register.
  - done=1 for this cycle only.
  - If the final carry is 1, set ovf; the sum is kept modulo 10^NDIG.
  - Next state is IDLE.
- Timing:
  - A transfer at cycle T gives done at T+NDIG+2.
  - in_ready is high again at T+NDIG+3.
  - Maximum throughput is one operand per NDIG+3 cycles.
- acc_xs3 never shows partial sums; it changes only on DONE, clr, or reset.
- clr, in any state:
  - Next edge: acc and working register return to all digits 4'b0011; ovf=0, err=0, state=IDLE.
  - An in-progress add is aborted with no done pulse.
  - clr together with in_valid: clr wins and no transfer occurs, because in_ready is low.
- busy = (state != IDLE).

Test Plan:
- Reset check: assert rst_n=0 mid-cycle -> immediately acc_xs3=12'h333, done=0, ovf=0, err=0, busy=0; after release, in_ready=1.
- Single add, NDIG=3: in_hi=4'h4, in_lo=4'h8 (decimal 15) at T -> done at T+5, acc_xs3=12'h348; repeat with the same operand -> acc_xs3=12'h363 (decimal 30), ovf=0.
- Carry chain and wrap, NDIG=2: add in_hi=4'hC, in_lo=4'hC (99) -> acc=8'hCC, ovf=0; add 99 again -> acc=8'hCB (98), ovf=1, and ovf stays 1 after a further add of 01.
- Illegal code: in_lo=4'b0001, in_hi=4'h3 -> err=1 two cycles after the transfer, no done pulse, acc unchanged, in_ready high on the following cycle.
- clr mid-ADD: assert clr during the second ADD cycle -> next cycle acc=12'h333, busy=0, ovf=0, err=0, no done pulse. Also: clr together with in_valid in IDLE -> no transfer occurs.
- Backpressure: hold in_valid=1 with a fixed operand for 20 cycles -> transfers only when in_ready=1, exactly one per NDIG+3 cycles, and each acc update equals the previous sum plus the operand.

Source files
------------

// File: rtl/xs3_accum.sv
// Excess-3 accumulator: adds a two-digit excess-3 operand into an NDIG-digit excess-3 running sum, one digit per clock.
// Latency: a transfer at cycle T gives a done pulse at T+NDIG+2; one operand per NDIG+3 cycles at most.
// Backpressure: in_ready is high only in IDLE with no clear pending; the source holds its data until accepted.
module xs3_accum #(
  parameter int NDIG = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_lo,
  input  logic [3:0]            in_hi,
  output logic [4*NDIG-1:0]     acc_xs3,
  output logic                  done,
  output logic                  busy,
  output logic                  ovf,
  output logic                  err
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);
  localparam logic [4*NDIG-1:0] ZERO_XS3 = {NDIG{4'b0011}};
  localparam logic [3:0] XS3_ZERO_DIGIT = 4'b0011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ADD   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched operand, working copy of the sum and digit-serial adder state.
  logic [3:0]          op_lo;
  logic [3:0]          op_hi;
  logic [4*NDIG-1:0]   work;
  logic [IW-1:0]       idx;
  logic                carry;

  // Combinational adder slice and helpers.
  logic [3:0]          digit_a;
  logic [3:0]          digit_b;
  logic [4:0]          raw;
  logic [3:0]          sum_digit;
  logic                carry_nxt;
  logic [4*NDIG-1:0]   work_nxt;
  logic                ops_legal;
  logic                xfer;
  logic                last_digit;

  function automatic logic is_legal(input logic [3:0] d);
    return (d >= 4'd3) && (d <= 4'd12);
  endfunction

  assign in_ready   = (state == IDLE) && !clr;
  assign xfer       = in_valid && in_ready;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign ops_legal  = is_legal(op_lo) && is_legal(op_hi);
  assign last_digit = (idx == LAST_IDX);

  // Select the accumulator digit and operand digit addressed by idx.
  always_comb begin
    digit_a = XS3_ZERO_DIGIT;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IW'(i)) begin
        digit_a = work[i*4 +: 4];
      end
    end
    if (idx == IW'(0)) begin
      digit_b = op_lo;
    end else if (idx == IW'(1)) begin
      digit_b = op_hi;
    end else begin
      digit_b = XS3_ZERO_DIGIT;
    end
  end

  // One excess-3 digit add: the binary sum of two xs3 digits carries a +6 bias,
  // so a decimal carry shows up as raw[4] and the bias is corrected by +3 or -3.
  always_comb begin
    raw = {1'b0, digit_a} + {1'b0, digit_b} + {4'b0000, carry};
    if (raw[4]) begin
      sum_digit = raw[3:0] + 4'd3;
      carry_nxt = 1'b1;
    end else begin
      sum_digit = raw[3:0] - 4'd3;
      carry_nxt = 1'b0;
    end
  end

  // Working register with the current digit replaced by the new sum digit.
  always_comb begin
    work_nxt = work;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IW'(i)) begin
        work_nxt[i*4 +: 4] = sum_digit;
      end
    end
  end

  // Next-state logic; clear always returns the FSM to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = CHECK;
      CHECK:   state_nxt = ops_legal ? ADD : IDLE;
      ADD:     if (last_digit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) begin
      state_nxt = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: operand capture, digit-serial add into the working copy, and
  // publication of the finished sum. The visible sum and ovf are written on the
  // edge that enters DONE so they are already valid while done is high; partial
  // sums only ever live in the working register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_xs3 <= ZERO_XS3;
      work    <= ZERO_XS3;
      op_lo   <= XS3_ZERO_DIGIT;
      op_hi   <= XS3_ZERO_DIGIT;
      idx     <= '0;
      carry   <= 1'b0;
      ovf     <= 1'b0;
      err     <= 1'b0;
    end else if (clr) begin
      acc_xs3 <= ZERO_XS3;
      work    <= ZERO_XS3;
      idx     <= '0;
      carry   <= 1'b0;
      ovf     <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            op_lo <= in_lo;
            op_hi <= in_hi;
            work  <= acc_xs3;
          end
        end
        CHECK: begin
          if (!ops_legal) begin
            err <= 1'b1;
          end
          idx   <= '0;
          carry <= 1'b0;
        end
        ADD: begin
          work  <= work_nxt;
          carry <= carry_nxt;
          idx   <= idx + 1'b1;
          if (last_digit) begin
            acc_xs3 <= work_nxt;
            if (carry_nxt) begin
              ovf <= 1'b1;
            end
          end
        end
        DONE: begin
          idx <= '0;
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

endmodule
